// File: rtl/hs_mul_seq.sv
// hs_mul_seq: ap_ctrl_hs shift-and-add multiplier; ap_done/ap_ready pulse WIDTH+1 cycles after accept, caller holds ap_start until ap_ready.
// Optional WORKING_KEY_EN adds the working_key port; ap_return is then XOR-masked by (working_key ^ KEY).
module hs_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter logic [7:0]  KEY   = 8'hA5
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef WORKING_KEY_EN
  input  logic [7:0]         working_key,
`endif
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic [2*WIDTH-1:0] ap_return
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ret_q, ret_d;
  logic [7:0]      key_diff;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ret_d    = ret_q;
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    case (state_q)
      IDLE: begin
        ap_idle = ~ap_start;
        if (ap_start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Fixed iteration count: no early exit even when the multiplier runs out of ones.
        if (cnt_q == LAST) begin
          ret_d   = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ret_q    <= ret_d;
    end
  end

`ifdef WORKING_KEY_EN
  assign key_diff = working_key ^ KEY;
`else
  // Without the key port the mask collapses to zero and KEY has no effect.
  assign key_diff = KEY ^ KEY;
`endif

  assign ap_return = ret_q ^ {(PW / 8){key_diff}};

endmodule

// File: tb/tb_hs_mul_seq.sv
// Bench for hs_mul_seq: directed and random operations checked against a plain-arithmetic product model.
module tb_hs_mul_seq;

  localparam int W = 32;

  logic           ap_clk = 1'b0;
  logic           ap_rst;
  logic           ap_start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ap_done;
  logic           ap_idle;
  logic           ap_ready;
  logic [2*W-1:0] ap_return;
`ifdef WORKING_KEY_EN
  logic [7:0]     working_key;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] last_ret;

  always #5 ap_clk = ~ap_clk;

  hs_mul_seq #(.WIDTH(W), .KEY(8'hA5)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .a         (a),
    .b         (b),
`ifdef WORKING_KEY_EN
    .working_key(working_key),
`endif
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .ap_return (ap_return)
  );

  function automatic logic [63:0] ref_ret(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
`ifdef WORKING_KEY_EN
    p = p ^ {8{working_key ^ 8'hA5}};
`endif
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Accept at cycle 0, then run through the DONE cycle (W+1); operands are scrambled while busy.
  task automatic op(input logic [31:0] x, input logic [31:0] y, input bit hold);
    logic [63:0] exp;
    exp = ref_ret(x, y);
    @(posedge ap_clk); #1;
    a = x; b = y; ap_start = 1'b1;
    @(negedge ap_clk);
    chk("accept_idle", 64'(ap_idle), 64'(0));
    chk("accept_done", 64'(ap_done), 64'(0));
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge ap_clk); #1;
      if (!hold) ap_start = 1'b0;
      a = $urandom; b = $urandom;
      @(negedge ap_clk);
      chk("done_timing", 64'(ap_done), 64'(k == W + 1));
      chk("ready_timing", 64'(ap_ready), 64'(k == W + 1));
      chk("idle_low", 64'(ap_idle), 64'(0));
      if (k == W + 1) chk("result", ap_return, exp);
    end
    last_ret = exp;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      @(negedge ap_clk);
      chk("gap_idle", 64'(ap_idle), 64'(1));
      chk("gap_done", 64'(ap_done), 64'(0));
      chk("gap_hold", ap_return, last_ret);
    end
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; a = '0; b = '0; last_ret = '0;
`ifdef WORKING_KEY_EN
    working_key = 8'hA5;
`endif
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_done", 64'(ap_done), 64'(0));
    chk("rst_ready", 64'(ap_ready), 64'(0));
    chk("rst_ret", ap_return, 64'(0));
    chk("rst_idle", 64'(ap_idle), 64'(1));

    op(32'd3, 32'd5, 1'b0);
    chk("basic_const", ap_return, 64'h0000_0000_0000_000F);
    idle_gap(2);

    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("max_const", ap_return, 64'hFFFF_FFFE_0000_0001);
    idle_gap(1);

    op(32'd7, 32'd6, 1'b1);
    chk("b2b_first", ap_return, 64'd42);
    op(32'd0, 32'd9, 1'b1);
    chk("b2b_second", ap_return, 64'd0);
    idle_gap(2);

    for (int r = 0; r < 6; r++) begin
      op($urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
    end
    idle_gap(1);

    op(32'd1234, 32'd5678, 1'b0);
    idle_gap(1);
    @(posedge ap_clk); #1;
    a = 32'd99; b = 32'd77; ap_start = 1'b1;
    @(negedge ap_clk);
    for (int k = 1; k <= 10; k++) begin
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      if (k == 10) ap_rst = 1'b1;
      @(negedge ap_clk);
      chk("abort_busy_done", 64'(ap_done), 64'(0));
    end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("abort_idle", 64'(ap_idle), 64'(1));
    chk("abort_ret", ap_return, 64'(0));
    chk("abort_ready", 64'(ap_ready), 64'(0));
    last_ret = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge ap_clk);
      chk("abort_no_done", 64'(ap_done), 64'(0));
    end
    chk("abort_ret_held", ap_return, 64'(0));

`ifdef WORKING_KEY_EN
    working_key = 8'h00;
    op(32'd2, 32'd3, 1'b0);
    chk("key_mismatch", ap_return, 64'hA5A5_A5A5_A5A5_A5A3);
    idle_gap(1);
    working_key = 8'hA5;
    op(32'd2, 32'd3, 1'b0);
    chk("key_match", ap_return, 64'd6);
    idle_gap(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_mul_seq.md
HS_MUL_SEQ -- requirements
Module: hs_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; the product width is 2*WIDTH.
REQ-002 SHALL have parameter KEY, default 8'hA5, giving the unlock value used only when WORKING_KEY_EN is defined.
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ap_start, input, 1 bit: request from the caller, held high until ap_ready is seen.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: unsigned operands, sampled on the accept cycle only.
REQ-007 SHALL have port ap_done, output, 1 bit: result valid pulse.
REQ-008 SHALL have port ap_idle, output, 1 bit: block is idle with no pending start.
REQ-009 SHALL have port ap_ready, output, 1 bit: inputs consumed, so the caller may drop or re-issue ap_start.
REQ-010 SHALL have port ap_return, output, 2*WIDTH bits: registered product.
REQ-011 SHALL have port working_key, input, 8 bits, present only when WORKING_KEY_EN is defined.

Function
REQ-012 SHALL implement the ap_ctrl_hs responder side as a one-hot FSM with states IDLE, BUSY and DONE.
REQ-013 IDLE: on ap_start=1, SHALL latch a into the multiplicand register, latch b into the multiplier register, clear the accumulator, clear the iteration counter and go to BUSY; otherwise SHALL stay in IDLE.
REQ-014 BUSY: each cycle, if multiplier bit 0 is 1, SHALL add the multiplicand to the accumulator; SHALL shift the multiplicand left 1, shift the multiplier right 1 and increment the counter.
REQ-015 BUSY: SHALL leave after exactly WIDTH iterations and go to DONE.
REQ-016 BUSY arithmetic: the accumulator and multiplicand SHALL be 2*WIDTH bits; no overflow is possible and no early termination is allowed.
REQ-017 On BUSY->DONE, SHALL load ap_return with the final accumulator value.
REQ-018 ap_return SHALL hold that value until the next BUSY->DONE transition or reset.
REQ-019 DONE: SHALL assert ap_done=1 and ap_ready=1 combinationally for exactly this one cycle, then go unconditionally to IDLE.
REQ-020 Latency SHALL be fixed: with accept at cycle 0 (IDLE, ap_start=1), ap_done is high at cycle WIDTH+1 (33 at default).
REQ-021 ap_idle SHALL be 1 iff state is IDLE and ap_start=0.
REQ-022 If ap_start is still 1 in the IDLE cycle after DONE, SHALL accept a new operation there; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-023 Changes on a, b or ap_start during BUSY or DONE SHALL be ignored.
REQ-024 ap_done and ap_ready SHALL be 0 in IDLE and BUSY.

Reset
REQ-025 While ap_rst=1 at a clock edge, SHALL enter IDLE and clear ap_return, the accumulator, the operand registers and the counter to 0; reset has priority over every transition.
REQ-026 Reset asserted mid-BUSY SHALL abort the operation with no ap_done and no ap_ready.
REQ-027 After reset: ap_done=0, ap_ready=0, ap_return=0, and ap_idle=1 while ap_start=0.

Configuration
REQ-028 Macro WORKING_KEY_EN, when defined, SHALL add the working_key port and drive ap_return = product XOR {2*WIDTH/8 copies of (working_key XOR KEY)}.
REQ-029 Under WORKING_KEY_EN, a correct key SHALL give the true product; the FSM timing SHALL be identical either way.
REQ-030 With WORKING_KEY_EN undefined, SHALL have no working_key port, and ap_return SHALL be the plain product.

Verification
REQ-031 Basic product: a=3, b=5, ap_start pulsed at cycle 0 -> ap_done=ap_ready=1 only at cycle 33; ap_return=64'h0000_0000_0000_000F, held afterwards.
REQ-032 Maximum operands: a=b=32'hFFFF_FFFF -> ap_return=64'hFFFF_FFFE_0000_0001.
REQ-033 Back-to-back: ap_start held at 1 with a=7, b=6, then a=0, b=9 -> first ap_done at cycle 33 with 42; second accepted at cycle 34; ap_done at cycle 67 with 0; ap_idle stays 0 throughout.
REQ-034 Reset mid-operation: ap_rst=1 at cycle 10 of BUSY -> next cycle IDLE, ap_return=0, no ap_done; ap_idle=1 once ap_start=0.
REQ-035 Key mismatch (WORKING_KEY_EN): working_key=8'h00, a=2, b=3 -> ap_return=64'hA5A5_A5A5_A5A5_A5A3.
REQ-036 Key match (WORKING_KEY_EN): working_key=8'hA5, a=2, b=3 -> ap_return=6; both key cases done at cycle 33.
